// File: rtl/rssi_log_conv.sv
// Three-stage linear-power to dB (1/32 dB) converter with hysteretic CCA and optional peak hold.
// Define RSSI_PEAK_HOLD_EN to build the peak-hold register; otherwise PEAK_DB is tied to 0.
module rssi_log_conv #(
  parameter int unsigned IN_WIDTH = 37,
  parameter int unsigned DB_WIDTH = 12
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic signed [IN_WIDTH-1:0] PWR,
  input  logic                       PWR_VALID,
  input  logic        [DB_WIDTH-1:0] TH_HI,
  input  logic        [DB_WIDTH-1:0] TH_LO,
  input  logic                       PEAK_CLR,
  output logic        [DB_WIDTH-1:0] RSSI_DB,
  output logic                       RSSI_VALID,
  output logic                       PWR_ZERO,
  output logic                       CCA_BUSY,
  output logic        [DB_WIDTH-1:0] PEAK_DB
);

  localparam int unsigned EW = $clog2(IN_WIDTH - 1);
  localparam int unsigned LW = EW + 5;
  localparam int unsigned PW = LW + 12;

  function automatic logic [4:0] log_lut(input logic [3:0] m);
    unique case (m)
      4'd0:  log_lut = 5'd0;
      4'd1:  log_lut = 5'd3;
      4'd2:  log_lut = 5'd5;
      4'd3:  log_lut = 5'd8;
      4'd4:  log_lut = 5'd10;
      4'd5:  log_lut = 5'd12;
      4'd6:  log_lut = 5'd14;
      4'd7:  log_lut = 5'd17;
      4'd8:  log_lut = 5'd19;
      4'd9:  log_lut = 5'd21;
      4'd10: log_lut = 5'd22;
      4'd11: log_lut = 5'd24;
      4'd12: log_lut = 5'd26;
      4'd13: log_lut = 5'd28;
      4'd14: log_lut = 5'd29;
      default: log_lut = 5'd31;
    endcase
  endfunction

  // Valid bits and outputs are reset; pipeline data registers are not.
  logic                v1_q, v2_q;
  logic [EW-1:0]       e_d, e_q;
  logic [3:0]          m_d, m_q;
  logic                z_d, z1_q, z2_q;
  logic [LW-1:0]       l_d, l_q;
  logic [PW-1:0]       prod;
  logic [DB_WIDTH-1:0] db_d, rssi_q;
  logic                rssi_valid_q, pwr_zero_q, cca_q;
  logic [IN_WIDTH+2:0] pad;

  // Leading-one search; pad puts four zeros below bit 0 so the mantissa window never underflows.
  always_comb begin
    e_d = '0;
    m_d = '0;
    pad = {PWR[IN_WIDTH-2:0], 4'b0000};
    for (int i = 0; i < int'(IN_WIDTH) - 1; i++) begin
      if (PWR[i]) begin
        e_d = EW'(i);
        m_d = pad[i +: 4];
      end
    end
    z_d = PWR[IN_WIDTH-1] || (PWR == '0);
  end

  always_comb begin
    l_d  = {e_q, 5'b00000} + LW'(log_lut(m_q));
    prod = PW'(l_q) * PW'(3083) + PW'(512);
    db_d = z2_q ? '0 : DB_WIDTH'(prod[PW-1:10]);
  end

  always_ff @(posedge CLK) begin
    e_q  <= e_d;
    m_q  <= m_d;
    z1_q <= z_d;
    l_q  <= l_d;
    z2_q <= z1_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      rssi_valid_q <= 1'b0;
      rssi_q       <= '0;
      pwr_zero_q   <= 1'b0;
      cca_q        <= 1'b0;
    end else begin
      v1_q         <= PWR_VALID;
      v2_q         <= v1_q;
      rssi_valid_q <= v2_q;
      if (v2_q) begin
        rssi_q     <= db_d;
        pwr_zero_q <= z2_q;
      end
      // Set is checked first so it wins when TH_LO > TH_HI.
      if (rssi_valid_q) begin
        if (rssi_q >= TH_HI) begin
          cca_q <= 1'b1;
        end else if (rssi_q < TH_LO) begin
          cca_q <= 1'b0;
        end
      end
    end
  end

`ifdef RSSI_PEAK_HOLD_EN
  logic [DB_WIDTH-1:0] peak_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      peak_q <= '0;
    end else if (rssi_valid_q && (PEAK_CLR || (rssi_q > peak_q))) begin
      peak_q <= rssi_q;
    end else if (PEAK_CLR) begin
      peak_q <= '0;
    end
  end

  assign PEAK_DB = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = PEAK_CLR;
  assign PEAK_DB         = '0;
`endif

  assign RSSI_DB    = rssi_q;
  assign RSSI_VALID = rssi_valid_q;
  assign PWR_ZERO   = pwr_zero_q;
  assign CCA_BUSY   = cca_q;

endmodule

// File: tb/tb_rssi_log_conv.sv
// Directed bench for rssi_log_conv: latency, conversion points, zero/negative input,
// CCA hysteresis, back-to-back samples, mid-pipeline reset and peak hold.
module tb_rssi_log_conv;

  localparam int IW = 37;
  localparam int DW = 12;

  logic                 CLK = 1'b0;
  logic                 RSTn;
  logic signed [IW-1:0] PWR;
  logic                 PWR_VALID;
  logic        [DW-1:0] TH_HI, TH_LO;
  logic                 PEAK_CLR;
  logic        [DW-1:0] RSSI_DB;
  logic                 RSSI_VALID;
  logic                 PWR_ZERO;
  logic                 CCA_BUSY;
  logic        [DW-1:0] PEAK_DB;

  int tests = 0;
  int fails = 0;
  int exp_peak = 0;

  rssi_log_conv #(.IN_WIDTH(IW), .DB_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .PWR       (PWR),
    .PWR_VALID (PWR_VALID),
    .TH_HI     (TH_HI),
    .TH_LO     (TH_LO),
    .PEAK_CLR  (PEAK_CLR),
    .RSSI_DB   (RSSI_DB),
    .RSSI_VALID(RSSI_VALID),
    .PWR_ZERO  (PWR_ZERO),
    .CCA_BUSY  (CCA_BUSY),
    .PEAK_DB   (PEAK_DB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, check the strobe lands exactly 3 cycles later, then check the
  // held output, CCA and peak one cycle after the strobe.
  task automatic send(input logic signed [IW-1:0] p, input int exp_db, input bit exp_zero,
                      input bit exp_cca, input bit clr, input string tag);
    PWR       = p;
    PWR_VALID = 1'b1;
    @(negedge CLK);
    PWR_VALID = 1'b0;
    chk({tag, " lat1"}, 32'(RSSI_VALID), 0);
    @(negedge CLK);
    chk({tag, " lat2"}, 32'(RSSI_VALID), 0);
    @(negedge CLK);
    chk({tag, " valid"}, 32'(RSSI_VALID), 1);
    chk({tag, " db"}, 32'(RSSI_DB), 32'(exp_db));
    chk({tag, " zero"}, 32'(PWR_ZERO), 32'(exp_zero));
    PEAK_CLR = clr;
`ifdef RSSI_PEAK_HOLD_EN
    if (clr || exp_db > exp_peak) exp_peak = exp_db;
`endif
    @(negedge CLK);
    PEAK_CLR = 1'b0;
    chk({tag, " strobe_end"}, 32'(RSSI_VALID), 0);
    chk({tag, " hold"}, 32'(RSSI_DB), 32'(exp_db));
    chk({tag, " cca"}, 32'(CCA_BUSY), 32'(exp_cca));
    chk({tag, " peak"}, 32'(PEAK_DB), 32'(exp_peak));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rssi_db"}, 32'(RSSI_DB), 0);
    chk({tag, " rssi_valid"}, 32'(RSSI_VALID), 0);
    chk({tag, " pwr_zero"}, 32'(PWR_ZERO), 0);
    chk({tag, " cca"}, 32'(CCA_BUSY), 0);
    chk({tag, " peak"}, 32'(PEAK_DB), 0);
  endtask

  initial begin
    RSTn      = 1'b0;
    PWR       = '0;
    PWR_VALID = 1'b0;
    TH_HI     = 12'd4095;
    TH_LO     = 12'd0;
    PEAK_CLR  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    // Conversion points; thresholds chosen so CCA never changes.
    send(37'sd1, 0, 1'b0, 1'b0, 1'b0, "pwr1");
    send(37'sd1024, 963, 1'b0, 1'b0, 1'b0, "pwr1024");
    send(37'sd3, 154, 1'b0, 1'b0, 1'b0, "pwr3");
    send(37'h0f_ffff_ffff, 3465, 1'b0, 1'b0, 1'b0, "pwrmax");
    send(37'sd0, 0, 1'b1, 1'b0, 1'b0, "pwr0");
    send(-37'sd5, 0, 1'b1, 1'b0, 1'b0, "pwrneg");

    // Back-to-back samples produce consecutive strobes.
    PWR = 37'sd1024; PWR_VALID = 1'b1;
    @(negedge CLK);
    PWR = 37'sd3;
    @(negedge CLK);
    PWR = 37'sd1024;
    @(negedge CLK);
    PWR_VALID = 1'b0;
    chk("b2b s0 valid", 32'(RSSI_VALID), 1);
    chk("b2b s0 db", 32'(RSSI_DB), 963);
    @(negedge CLK);
    chk("b2b s1 valid", 32'(RSSI_VALID), 1);
    chk("b2b s1 db", 32'(RSSI_DB), 154);
    @(negedge CLK);
    chk("b2b s2 valid", 32'(RSSI_VALID), 1);
    chk("b2b s2 db", 32'(RSSI_DB), 963);

    // Refill the pipeline, then reset while it is full.
    PWR = 37'sd1024; PWR_VALID = 1'b1;
    @(negedge CLK);
    PWR = 37'sd3;
    @(negedge CLK);
    PWR = 37'sd1024;
    @(negedge CLK);
    PWR_VALID = 1'b0;
    chk("full s0 valid", 32'(RSSI_VALID), 1);
    RSTn = 1'b0;
    exp_peak = 0;
    #1;
    chk_all_zero("midreset");
    @(negedge CLK);
    RSTn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("no stale strobe", 32'(RSSI_VALID), 0);
    end
    chk_all_zero("post reset");

    // Hysteresis, including the exact TH_HI boundary.
    TH_HI = 12'd960;
    TH_LO = 12'd900;
    send(37'sd1024, 963, 1'b0, 1'b1, 1'b0, "hyst set");
    send(37'sd960, 954, 1'b0, 1'b1, 1'b0, "hyst hold");
    send(37'sd0, 0, 1'b1, 1'b0, 1'b0, "hyst clear");
    send(37'sd992, 960, 1'b0, 1'b1, 1'b0, "hyst eq");
    send(37'sd0, 0, 1'b1, 1'b0, 1'b0, "hyst clear2");

    // Inverted thresholds: set beats clear.
    TH_HI = 12'd100;
    TH_LO = 12'd200;
    send(37'sd3, 154, 1'b0, 1'b1, 1'b0, "prio set");
    send(37'sd1, 0, 1'b0, 1'b0, 1'b0, "prio clear");

    // Peak hold; clear coincident with a strobe loads the new value.
    TH_HI = 12'd4095;
    TH_LO = 12'd0;
    send(37'sd3, 154, 1'b0, 1'b0, 1'b1, "peak clr0");
    send(37'sd1024, 963, 1'b0, 1'b0, 1'b0, "peak hi");
    send(37'sd3, 154, 1'b0, 1'b0, 1'b0, "peak keep");
    send(37'sd3, 154, 1'b0, 1'b0, 1'b1, "peak clr1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
